// File: rtl/array_shift_nbit.sv
// array_shift_nbit
//   Multi-word big-integer shifter. Reads an operand of len words (word 0 is
//   least significant) from a RAM read port, shifts the whole operand left or
//   right by 0..DATA_WIDTH-1 bits (logical, or arithmetic for right shifts) and
//   streams the result words, lowest address first, to a RAM write port.
//   Every write to address i lands after the last read of address i, so the
//   read and write ports may share one RAM.
//
// Ports
//   CLK, RST_N   clock (rising edge), asynchronous active-low reset
//   start        begin an operation (accepted only while idle)
//   dir          0 = right shift, 1 = left shift
//   arith        right shift only: fill vacated top bits with the operand sign
//   shamt        shift amount in bits
//   len          operand length in words (values above NUM_WORDS are clamped)
//   busy         high from the cycle after an accepted start until done
//   done         one-cycle completion pulse
//   rd_en/rd_addr/rd_data   read port, data returns RD_LAT cycles after rd_en
//   wr_en/wr_addr/wr_data   write port for the shifted words
module array_shift_nbit #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LAT     = 2,
  localparam int SHW       = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic                  dir,
  input  logic                  arith,
  input  logic [SHW-1:0]        shamt,
  input  logic [ADDR_WIDTH-1:0] len,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, next_state;

  logic                  dir_q;
  logic                  arith_q;
  logic [SHW-1:0]        shamt_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [ADDR_WIDTH-1:0] in_cnt;
  logic [RD_LAT-1:0]     vpipe;
  logic [DATA_WIDTH-1:0] prev_q;
  logic                  tail_q;

  logic                    accept;
  logic                    tag;
  logic                    last_rd;
  logic                    last_in;
  logic                    last_wr;
  logic [DATA_WIDTH-1:0]   fill;
  logic [2*DATA_WIDTH-1:0] cat;
  logic [2*DATA_WIDTH-1:0] cat_l;
  logic [2*DATA_WIDTH-1:0] cat_r;
  logic [DATA_WIDTH-1:0]   shifted;

  assign accept  = (state == IDLE) && start;
  assign tag     = vpipe[RD_LAT-1];
  assign last_rd = (rd_cnt == len_q - ADDR_WIDTH'(1));
  assign last_in = (in_cnt == len_q - ADDR_WIDTH'(1));
  // Left shifts write as each word arrives; right shifts finish with the
  // extra tail write of the top word one cycle after the last arrival.
  assign last_wr = dir_q ? (tag && last_in) : tail_q;

  // The pair {upper, lower} is shifted as one double-width value and a single
  // word sliced out, so a zero shift amount never needs a full-width shift.
  // For the tail word of a right shift the upper half is the fill pattern.
  assign fill    = arith_q ? {DATA_WIDTH{prev_q[DATA_WIDTH-1]}} : '0;
  assign cat     = {(tail_q ? fill : rd_data), prev_q};
  assign cat_l   = cat << shamt_q;
  assign cat_r   = cat >> shamt_q;
  assign shifted = dir_q ? cat_l[2*DATA_WIDTH-1:DATA_WIDTH] : cat_r[DATA_WIDTH-1:0];

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a zero-length operand skips straight to DONE
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = (len == '0) ? DONE : READ;
      READ:    if (last_rd) next_state = DRAIN;
      DRAIN:   if (last_wr) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy    = (state != IDLE);
    rd_en   = (state == READ);
    rd_addr = (state == READ) ? rd_cnt : '0;
  end

  // Datapath: operand latching, read counter, valid-tag pipe, word assembly
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
      shamt_q <= '0;
      len_q   <= '0;
      rd_cnt  <= '0;
      in_cnt  <= '0;
      vpipe   <= '0;
      prev_q  <= '0;
      tail_q  <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      vpipe  <= (vpipe << 1) | RD_LAT'(rd_en);
      done   <= (state == DONE);
      wr_en  <= 1'b0;
      tail_q <= 1'b0;

      if (accept) begin
        dir_q   <= dir;
        arith_q <= arith;
        shamt_q <= shamt;
        len_q   <= (len > ADDR_WIDTH'(NUM_WORDS)) ? ADDR_WIDTH'(NUM_WORDS) : len;
        rd_cnt  <= '0;
        in_cnt  <= '0;
        prev_q  <= '0;
      end

      if (state == READ) begin
        rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
      end

      // A right-shift result word needs the next word up, so output i is
      // produced when word i+1 arrives; left shifts emit on arrival.
      if (tag) begin
        prev_q <= rd_data;
        in_cnt <= in_cnt + ADDR_WIDTH'(1);
        if (dir_q) begin
          wr_en   <= 1'b1;
          wr_addr <= in_cnt;
          wr_data <= shifted;
        end else begin
          if (in_cnt != '0) begin
            wr_en   <= 1'b1;
            wr_addr <= in_cnt - ADDR_WIDTH'(1);
            wr_data <= shifted;
          end
          if (last_in) begin
            tail_q <= 1'b1;
          end
        end
      end

      if (tail_q) begin
        wr_en   <= 1'b1;
        wr_addr <= len_q - ADDR_WIDTH'(1);
        wr_data <= shifted;
      end
    end
  end

endmodule
